// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment driver for a bank of DIGITS
// digits on one shared segment bus. Loaded data is double-buffered and is
// moved to the display only when the scan index wraps, so a frame never
// shows a mix of old and new digits.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  com,
  input  logic                  enb,
  input  logic                  lzb,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   dat_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  upd_pend,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_act_dat, r_sh_dat;
  logic [DIGITS-1:0]   r_act_dp, r_sh_dp;
  logic                r_pend;
  logic                r_frame_done;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;

  logic                w_tick;
  logic                w_wrap;
  logic [3:0]          w_nib;
  logic                w_dpbit;
  logic                w_blank;
  logic [DIGITS-1:0]   w_zero_from;
  logic [DIGITS-1:0]   w_onehot;
  logic [6:0]          w_seg_n;
  logic                w_dp_n;
  logic [DIGITS-1:0]   w_an_n;

  assign w_tick = (r_presc == LAST_CNT);
  assign w_wrap = w_tick && (r_idx == LAST_IDX);

  // Active-low segment pattern for one hex nibble.
  function automatic logic [6:0] f_decode(input logic [3:0] n);
    case (n)
      4'h0: f_decode = 7'h40;
      4'h1: f_decode = 7'h79;
      4'h2: f_decode = 7'h24;
      4'h3: f_decode = 7'h30;
      4'h4: f_decode = 7'h19;
      4'h5: f_decode = 7'h12;
      4'h6: f_decode = 7'h02;
      4'h7: f_decode = 7'h78;
      4'h8: f_decode = 7'h00;
      4'h9: f_decode = 7'h10;
      4'hA: f_decode = 7'h08;
      4'hB: f_decode = 7'h03;
      4'hC: f_decode = 7'h46;
      4'hD: f_decode = 7'h21;
      4'hE: f_decode = 7'h06;
      default: f_decode = 7'h0E;
    endcase
  endfunction

  // Prescaler: counts 0..REFRESH_DIV-1, tick on the last count.
  always_ff @(posedge clk) begin
    if (rst || w_tick) r_presc <= '0;
    else               r_presc <= r_presc + 1'b1;
  end

  // Digit index: advances per tick, wraps DIGITS-1 -> 0.
  always_ff @(posedge clk) begin
    if (rst)         r_idx <= '0;
    else if (w_wrap) r_idx <= '0;
    else if (w_tick) r_idx <= r_idx + 1'b1;
  end

  // Shadow/active double buffer; a load on the wrap tick still lands in
  // shadow while the older shadow content moves to active.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_dat    <= '0;
      r_act_dp     <= '0;
      r_sh_dat     <= '0;
      r_sh_dp      <= '0;
      r_pend       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_wrap && r_pend) begin
        r_act_dat <= r_sh_dat;
        r_act_dp  <= r_sh_dp;
      end
      if (ld) begin
        r_sh_dat <= dat_in;
        r_sh_dp  <= dp_in;
      end
      r_pend       <= ld ? 1'b1 : (w_wrap ? 1'b0 : r_pend);
      r_frame_done <= w_wrap;
    end
  end

  // Select the current digit and work out leading-zero blanking.
  always_comb begin
    w_nib       = '0;
    w_dpbit     = 1'b0;
    w_blank     = 1'b0;
    w_onehot    = '0;
    w_zero_from = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (k == 0)
        w_zero_from[DIGITS-1] = (r_act_dat[4*(DIGITS-1) +: 4] == 4'h0);
      else
        w_zero_from[DIGITS-1-k] = w_zero_from[DIGITS-k] &&
                                  (r_act_dat[4*(DIGITS-1-k) +: 4] == 4'h0);
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == r_idx) begin
        w_nib       = r_act_dat[4*i +: 4];
        w_dpbit     = r_act_dp[i];
        w_blank     = lzb && (i != 0) && w_zero_from[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Build the active-low output image, honouring enable.
  always_comb begin
    w_seg_n = '1;
    w_dp_n  = 1'b1;
    w_an_n  = '1;
    if (enb) begin
      w_seg_n = w_blank ? 7'h7F : f_decode(w_nib);
      w_dp_n  = ~w_dpbit;
      w_an_n  = ~w_onehot;
    end
  end

  // Output register with polarity applied; reset shows the blank pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= com ? '1 : '0;
      r_dp  <= com;
      r_an  <= com ? '1 : '0;
    end else begin
      r_seg <= com ? w_seg_n : ~w_seg_n;
      r_dp  <= com ? w_dp_n  : ~w_dp_n;
      r_an  <= com ? w_an_n  : ~w_an_n;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign upd_pend   = r_pend;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4). A cycle-count
// reference model predicts every output after every clock edge.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst, com, enb, lzb, ld;
  logic [15:0]   dat_in;
  logic [3:0]    dp_in;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          upd_pend, frame_done;

  seg7_scan_driver #(.DIGITS(ND), .REFRESH_DIV(RD), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .com(com), .enb(enb), .lzb(lzb), .ld(ld),
    .dat_in(dat_in), .dp_in(dp_in), .seg(seg), .dp(dp), .an(an),
    .upd_pend(upd_pend), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Active-low hex patterns 0..F.
  logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int failures = 0;

  // Reference model state: cycles since reset plus the two buffers.
  int          m_cyc;
  logic [15:0] m_act_d, m_sh_d;
  logic [3:0]  m_act_p, m_sh_p;
  bit          m_pend;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;
  logic [3:0]  e_an;

  task automatic model_edge();
    int idx, presc;
    bit wrap, blank;
    logic [3:0] nib;
    if (rst) begin
      e_seg = com ? 7'h7F : 7'h00;
      e_dp  = com;
      e_an  = com ? 4'hF : 4'h0;
      e_fd  = 1'b0;
      m_cyc = 0; m_act_d = '0; m_act_p = '0; m_sh_d = '0; m_sh_p = '0; m_pend = 0;
    end else begin
      presc = m_cyc % RD;
      idx   = (m_cyc / RD) % ND;
      wrap  = (presc == RD - 1) && (idx == ND - 1);
      if (!enb) begin
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
      end else begin
        nib   = m_act_d[4*idx +: 4];
        blank = lzb && (idx != 0) && ((m_act_d >> (4*idx)) == 16'h0);
        e_seg = blank ? 7'h7F : DEC[nib];
        e_dp  = ~m_act_p[idx];
        e_an  = ~(4'b0001 << idx);
      end
      if (!com) begin
        e_seg = ~e_seg; e_dp = ~e_dp; e_an = ~e_an;
      end
      e_fd = wrap;
      if (wrap && m_pend) begin
        m_act_d = m_sh_d; m_act_p = m_sh_p;
      end
      if (ld) begin
        m_sh_d = dat_in; m_sh_p = dp_in;
      end
      m_pend = ld ? 1'b1 : (wrap ? 1'b0 : m_pend);
      m_cyc++;
    end
  endtask

  task automatic check_all();
    checks++;
    assert (seg === e_seg) else begin
      failures++; $error("FAIL seg obs=%h exp=%h cyc=%0d", seg, e_seg, m_cyc);
    end
    checks++;
    assert (dp === e_dp) else begin
      failures++; $error("FAIL dp obs=%b exp=%b cyc=%0d", dp, e_dp, m_cyc);
    end
    checks++;
    assert (an === e_an) else begin
      failures++; $error("FAIL an obs=%b exp=%b cyc=%0d", an, e_an, m_cyc);
    end
    checks++;
    assert (frame_done === e_fd) else begin
      failures++; $error("FAIL frame_done obs=%b exp=%b cyc=%0d", frame_done, e_fd, m_cyc);
    end
    checks++;
    assert (upd_pend === m_pend) else begin
      failures++; $error("FAIL upd_pend obs=%b exp=%b cyc=%0d", upd_pend, m_pend, m_cyc);
    end
  endtask

  // One clock: edge, model update, check 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    ld = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p);
    dat_in = d; dp_in = p; ld = 1'b1;
    cyc();
  endtask

  task automatic wait_fd();
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cyc();
      if (frame_done === 1'b1) got = 1;
    end
    checks++;
    assert (got) else begin
      failures++; $error("FAIL wait_frame_done obs=timeout exp=pulse");
    end
  endtask

  initial begin
    rst = 1'b1; com = 1'b1; enb = 1'b1; lzb = 1'b0; ld = 1'b0;
    dat_in = '0; dp_in = '0;
    #12;
    rst = 1'b1;
    cyc();
    // Reset values stated literally.
    checks++;
    assert (seg === 7'h7F && an === 4'hF && dp === 1'b1 && upd_pend === 1'b0) else begin
      failures++; $error("FAIL reset_blank obs=%h/%b/%b exp=7f/1111/1", seg, an, dp);
    end

    // Common anode scan of 12AF.
    load(16'h12AF, 4'b0000);
    wait_fd();
    cyc();
    checks++;
    assert (seg === 7'h0E && an === 4'b1110) else begin
      failures++; $error("FAIL digit0_ca obs=%h/%b exp=0e/1110", seg, an);
    end
    run(4);
    checks++;
    assert (seg === 7'h08 && an === 4'b1101) else begin
      failures++; $error("FAIL digit1_ca obs=%h/%b exp=08/1101", seg, an);
    end
    run(40);

    // Common cathode.
    com = 1'b0;
    run(36);

    // Leading-zero blanking, then without.
    com = 1'b1; lzb = 1'b1;
    load(16'h0005, 4'b0100);
    wait_fd();
    run(20);
    lzb = 1'b0;
    run(20);

    // Two loads mid-frame; only the last one is shown.
    while (m_cyc % 16 != 5) cyc();
    load(16'h1111, 4'b0001);
    run(2);
    load(16'h2222, 4'b0010);
    wait_fd();
    run(20);

    // Load coincident with the wrap tick.
    load(16'h3333, 4'b0000);
    while (m_cyc % 16 != 15) cyc();
    load(16'h4444, 4'b1000);
    run(36);

    // Reset mid-scan with a pending update.
    run(5);
    load(16'h5555, 4'b1111);
    run(2);
    rst = 1'b1;
    cyc();
    run(20);

    // Enable pulse.
    load(16'hBEEF, 4'b0101);
    run(7);
    enb = 1'b0;
    run(3);
    enb = 1'b1;
    run(30);

    // Randomized operation.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        ld = 1'b1;
        for (int k = 0; k < 4; k++)
          dat_in[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        dp_in = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 49) == 0) com = ~com;
      if ($urandom_range(0, 19) == 0) enb = ~enb;
      if ($urandom_range(0, 29) == 0) lzb = ~lzb;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
